iterative_alu: RTL and testbench
================================

// Module: iterative_alu
// PURPOSE
//  Parametrised multi-cycle ALU for the datapath.
//  - Logic, add/sub and shift ops complete in 1 cycle.
//  - Signed MUL uses a Booth multiplier; signed DIV uses a non-restoring divider. Both are iterative.
//  - Results go to a {HI,LO} register pair. The control unit drives operations with a start/done handshake.
// PARAMETERS
//  WIDTH   32  operand width; even, >= 8
//  SHW     $clog2(WIDTH)  shift-amount bits taken from input_b (derived localparam)
// PORTS
//  clock      in   1        rising-edge clock
//  clear      in   1        asynchronous, active-high reset
//  start      in   1        begin op; sampled only in IDLE
//  opcode     in   4        0 OR,1 AND,2 NOT,3 ADD,4 SUB,5 NEG,6 MUL,7 DIV,8 SHL,9 SHR,10 SHRA,11 ROL,12 ROR
//  input_a    in   WIDTH    operand A / dividend / multiplicand
//  input_b    in   WIDTH    operand B / divisor / multiplier / shift amount
//  busy       out  1        high from the cycle after start until done
//  done       out  1        1-cycle pulse; results valid from this cycle on
//  result_lo  out  WIDTH    LO: result, product[WIDTH-1:0], or quotient
//  result_hi  out  WIDTH    HI: product[2W-1:W] or remainder; 0 for all other ops
//  overflow   out  1        signed overflow (ADD/SUB/NEG, DIV MIN/-1); else 0
//  div_zero   out  1        DIV with input_b==0
// BEHAVIOUR
//  - Reset: clear=1 forces IDLE immediately. busy, done, result_lo, result_hi, overflow and div_zero all go to 0.
//  - clear mid-op aborts the op. No done pulse is produced.
//  - FSM states: IDLE, MUL, DIV, DIVFIX, DONE.
//  - IDLE + start: latch opcode and operands (edge E0).
//    - Ops 0-5, 8-12, 13-15, and DIV with zero divisor: result is computed at E0, then go to DONE.
//    - Op 6: load counter = WIDTH, go to MUL.
//    - Op 7 with input_b != 0: load counter = WIDTH, go to DIV.
//  - MUL: one radix-2 Booth step per cycle. When the counter reaches 0, go to DONE.
//  - DIV: one non-restoring step per cycle on |A|/|B|. At count 0, go to DIVFIX.
//  - DIVFIX: restore a negative remainder, then apply signs. Go to DONE.
//  - DONE: done=1, busy=0 for one cycle, then IDLE. A start seen in DONE is ignored.
//  - Latency from the start edge to done high: single-cycle ops 1, MUL WIDTH+1, DIV WIDTH+2.
//  - start while busy is ignored. Latched operands are immune to input changes after E0.
//  - Outputs hold their last values until the next op's done cycle.
//    - Exception: div_zero and overflow are rewritten with every result.
//  - Arithmetic is WIDTH-bit two's complement. ADD/SUB/NEG wrap.
//    - overflow is set per signed rules; NEG of MIN sets overflow and returns MIN.
//  - Shifts use input_b[SHW-1:0] only. Amount 0 returns A. SHRA sign-fills; ROL/ROR rotate modulo WIDTH.
//  - MUL: signed x signed gives a 2*WIDTH-bit product.
//  - DIV: truncates toward zero; the remainder takes the sign of the dividend.
//    - MIN/-1: quotient=MIN, remainder=0, overflow=1.
//    - B==0: div_zero=1, LO=all ones, HI=A, 1-cycle latency.
//  - Opcodes 13-15: LO=HI=0, flags 0, 1-cycle latency.
// CONFIGURATION
//  - `ALU_RADIX4_BOOTH_EN` defined: MUL uses radix-4 bit-pair recoding.
//    - counter = WIDTH/2; MUL latency = WIDTH/2+1; product bits are identical to radix-2.
//  - Not defined: radix-2 Booth, MUL latency WIDTH+1. DIV and all other ops are unaffected either way.
// TESTING (WIDTH=32)
//  - ADD 20,5 -> LO=25, HI=0, overflow=0.
//    - done 1 cycle after the start edge.
//    - ADD 0x7FFFFFFF,1 -> LO=0x80000000, overflow=1.
//  - MUL -20,5 -> {HI,LO}=0xFFFFFFFF_FFFFFF9C.
//    - done exactly 33 cycles after start (17 with the macro defined).
//  - DIV 20,-3 -> LO=0xFFFFFFFA (-6), HI=2 in 34 cycles.
//    - DIV 20,0 -> div_zero=1, LO=0xFFFFFFFF, HI=20, 1 cycle.
//  - Shifts: ROR 0xB2 by 2 -> 0x8000002C; SHRA 0x80000000 by 4 -> 0xF8000000.
//    - SHL 0xB2 by 34 -> 0x2C8 (amount taken mod 32).
//  - Start MUL, then pulse start with new operands at cycle 5 -> ignored; the original product is returned.
//  - clear asserted at cycle 10 of a MUL -> busy=0 and all outputs 0 at once; no done pulse.
//    - Next ADD completes normally.

Source files
------------

// File: rtl/iterative_alu.sv
// iterative_alu: multi-cycle ALU with Booth multiplier and non-restoring divider.
// Define ALU_RADIX4_BOOTH_EN to switch MUL to radix-4 bit-pair Booth recoding.
module iterative_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow,
    output logic             div_zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);
`ifdef ALU_RADIX4_BOOTH_EN
    localparam int MUL_STEPS = WIDTH / 2;
`else
    localparam int MUL_STEPS = WIDTH;
`endif
    localparam logic [CW-1:0]    MUL_CNT = CW'(MUL_STEPS);
    localparam logic [CW-1:0]    DIV_CNT = CW'(WIDTH);
    localparam logic [CW-1:0]    ONE_CNT = CW'(1);
    localparam logic [SHW:0]     WSZ     = (SHW + 1)'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0] ZERO    = '0;

    localparam logic [3:0] OP_OR   = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_NEG  = 4'd5;
    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_DIV  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_SHRA = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_ROR  = 4'd12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DIVFIX,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]    count;

    // Booth working registers: {acc_hi, acc_lo, acc_q} is the shifting product
    logic [WIDTH-1:0] mcand;
    logic [WIDTH+1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             acc_q;

    // Divider working registers operate on magnitudes
    logic [WIDTH+1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             sign_q;
    logic             sign_r;
    logic             div_ovf;

    logic             msb_a;
    logic             msb_b;
    logic             quick_op;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    logic [SHW-1:0]   shamt;
    logic [SHW-1:0]   rotamt;
    logic [SHW:0]     rot_inv;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] neg;

    logic [WIDTH-1:0] q_lo;
    logic [WIDTH-1:0] q_hi;
    logic             q_ovf;
    logic             q_dz;

    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] booth_sum;
    logic [WIDTH+1:0] booth_hi_nxt;
    logic [WIDTH-1:0] booth_lo_nxt;
    logic             booth_q_nxt;

    logic [WIDTH+1:0] d_ext;
    logic [WIDTH+1:0] div_shift;
    logic [WIDTH+1:0] div_rem_nxt;
    logic [WIDTH-1:0] div_quo_nxt;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] quo_out;
    logic [WIDTH-1:0] rem_out;

    assign msb_a = input_a[WIDTH-1];
    assign msb_b = input_b[WIDTH-1];
    assign a_abs = msb_a ? (ZERO - input_a) : input_a;
    assign b_abs = msb_b ? (ZERO - input_b) : input_b;

    // MUL and non-zero DIV iterate; everything else resolves at the start edge
    assign quick_op = !((opcode == OP_MUL) ||
                        ((opcode == OP_DIV) && (input_b != ZERO)));

    assign shamt   = input_b[SHW-1:0];
    assign rotamt  = ({1'b0, shamt} >= WSZ) ? (shamt - WSZ[SHW-1:0]) : shamt;
    assign rot_inv = WSZ - {1'b0, rotamt};
    assign sum     = input_a + input_b;
    assign diff    = input_a - input_b;
    assign neg     = ZERO - input_a;

    // Single-cycle result selection straight from the live operands
    always_comb begin
        q_lo  = '0;
        q_hi  = '0;
        q_ovf = 1'b0;
        q_dz  = 1'b0;
        case (opcode)
            OP_OR:   q_lo = input_a | input_b;
            OP_AND:  q_lo = input_a & input_b;
            OP_NOT:  q_lo = ~input_a;
            OP_ADD: begin
                q_lo  = sum;
                q_ovf = (msb_a == msb_b) && (sum[WIDTH-1] != msb_a);
            end
            OP_SUB: begin
                q_lo  = diff;
                q_ovf = (msb_a != msb_b) && (diff[WIDTH-1] != msb_a);
            end
            OP_NEG: begin
                q_lo  = neg;
                q_ovf = (input_a == MIN_VAL);
            end
            OP_DIV: begin
                q_lo = '1;
                q_hi = input_a;
                q_dz = 1'b1;
            end
            OP_SHL:  q_lo = input_a << shamt;
            OP_SHR:  q_lo = input_a >> shamt;
            OP_SHRA: q_lo = $signed(input_a) >>> shamt;
            OP_ROL:  q_lo = (input_a << rotamt) | (input_a >> rot_inv);
            OP_ROR:  q_lo = (input_a >> rotamt) | (input_a << rot_inv);
            default: q_lo = '0;
        endcase
    end

    assign m_ext = {{2{mcand[WIDTH-1]}}, mcand};

`ifdef ALU_RADIX4_BOOTH_EN
    // Radix-4 Booth step: recode a bit pair, add 0/+-M/+-2M, shift by two
    always_comb begin
        booth_sum = acc_hi;
        case ({acc_lo[1:0], acc_q})
            3'b001, 3'b010: booth_sum = acc_hi + m_ext;
            3'b011:         booth_sum = acc_hi + {m_ext[WIDTH:0], 1'b0};
            3'b100:         booth_sum = acc_hi - {m_ext[WIDTH:0], 1'b0};
            3'b101, 3'b110: booth_sum = acc_hi - m_ext;
            default:        booth_sum = acc_hi;
        endcase
        booth_hi_nxt = {{2{booth_sum[WIDTH+1]}}, booth_sum[WIDTH+1:2]};
        booth_lo_nxt = {booth_sum[1:0], acc_lo[WIDTH-1:2]};
        booth_q_nxt  = acc_lo[1];
    end
`else
    // Radix-2 Booth step: add/sub M on a 01/10 pair, then shift by one
    always_comb begin
        booth_sum = acc_hi;
        case ({acc_lo[0], acc_q})
            2'b01:   booth_sum = acc_hi + m_ext;
            2'b10:   booth_sum = acc_hi - m_ext;
            default: booth_sum = acc_hi;
        endcase
        booth_hi_nxt = {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
        booth_lo_nxt = {booth_sum[0], acc_lo[WIDTH-1:1]};
        booth_q_nxt  = acc_lo[0];
    end
`endif

    assign d_ext = {2'b00, dvsr};

    // Non-restoring step plus the final remainder fix-up and sign application
    always_comb begin
        div_shift   = {rem[WIDTH:0], quo[WIDTH-1]};
        div_rem_nxt = rem[WIDTH+1] ? (div_shift + d_ext) : (div_shift - d_ext);
        div_quo_nxt = {quo[WIDTH-2:0], ~div_rem_nxt[WIDTH+1]};
        rem_mag     = rem[WIDTH+1] ? (rem[WIDTH-1:0] + dvsr) : rem[WIDTH-1:0];
        quo_out     = sign_q ? (ZERO - quo) : quo;
        rem_out     = sign_r ? (ZERO - rem_mag) : rem_mag;
    end

    // State register
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (opcode == OP_MUL) begin
                        state_nxt = S_MUL;
                    end else if (!quick_op) begin
                        state_nxt = S_DIV;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_MUL: begin
                busy = 1'b1;
                if (count == ONE_CNT) begin
                    state_nxt = S_DONE;
                end
            end
            S_DIV: begin
                busy = 1'b1;
                if (count == ONE_CNT) begin
                    state_nxt = S_DIVFIX;
                end
            end
            S_DIVFIX: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count     <= '0;
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            acc_q     <= 1'b0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            div_ovf   <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            overflow  <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count   <= (opcode == OP_MUL) ? MUL_CNT : DIV_CNT;
                        mcand   <= input_a;
                        acc_hi  <= '0;
                        acc_lo  <= input_b;
                        acc_q   <= 1'b0;
                        rem     <= '0;
                        quo     <= a_abs;
                        dvsr    <= b_abs;
                        sign_q  <= msb_a ^ msb_b;
                        sign_r  <= msb_a;
                        div_ovf <= (input_a == MIN_VAL) && (input_b == '1);
                        if (quick_op) begin
                            result_lo <= q_lo;
                            result_hi <= q_hi;
                            overflow  <= q_ovf;
                            div_zero  <= q_dz;
                        end
                    end
                end
                S_MUL: begin
                    acc_hi <= booth_hi_nxt;
                    acc_lo <= booth_lo_nxt;
                    acc_q  <= booth_q_nxt;
                    count  <= count - ONE_CNT;
                    if (count == ONE_CNT) begin
                        result_lo <= booth_lo_nxt;
                        result_hi <= booth_hi_nxt[WIDTH-1:0];
                        overflow  <= 1'b0;
                        div_zero  <= 1'b0;
                    end
                end
                S_DIV: begin
                    rem   <= div_rem_nxt;
                    quo   <= div_quo_nxt;
                    count <= count - ONE_CNT;
                end
                S_DIVFIX: begin
                    result_lo <= quo_out;
                    result_hi <= rem_out;
                    overflow  <= div_ovf;
                    div_zero  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: randomized scoreboard bench for iterative_alu (WIDTH=32).
// Expected results come from a plain-arithmetic reference model.
module tb_iterative_alu;

    localparam int W = 32;
`ifdef ALU_RADIX4_BOOTH_EN
    localparam int MUL_LAT = W / 2 + 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 2;
    localparam logic [W-1:0] MINV = 32'h8000_0000;
    localparam logic [W-1:0] MAXV = 32'h7FFF_FFFF;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clock = 1'b0;
    logic         clear;
    logic         start;
    logic [3:0]   opcode;
    logic [W-1:0] input_a;
    logic [W-1:0] input_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         overflow;
    logic         div_zero;

    iterative_alu #(.WIDTH(W)) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .opcode    (opcode),
        .input_a   (input_a),
        .input_b   (input_b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .overflow  (overflow),
        .div_zero  (div_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         ovf;
        logic         dz;
        int           lat;
        int           t0;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(string nm, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t model(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint r;
        longint q;
        int     amt;
        logic [W-1:0] v;
        e.lo = '0; e.hi = '0; e.ovf = 1'b0; e.dz = 1'b0; e.lat = 1; e.t0 = 0;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        amt = int'(b % 32'(W));
        v   = a;
        case (op)
            4'd0: e.lo = a | b;
            4'd1: e.lo = a & b;
            4'd2: e.lo = ~a;
            4'd3: begin r = sa + sb; e.lo = r[31:0]; e.ovf = (r > SMAX) || (r < SMIN); end
            4'd4: begin r = sa - sb; e.lo = r[31:0]; e.ovf = (r > SMAX) || (r < SMIN); end
            4'd5: begin r = -sa; e.lo = r[31:0]; e.ovf = (r > SMAX); end
            4'd6: begin r = sa * sb; e.lo = r[31:0]; e.hi = r[63:32]; e.lat = MUL_LAT; end
            4'd7: begin
                if (b == '0) begin
                    e.lo = '1; e.hi = a; e.dz = 1'b1;
                end else if (a == MINV && sb == -1) begin
                    e.lo = MINV; e.hi = '0; e.ovf = 1'b1; e.lat = DIV_LAT;
                end else begin
                    q = sa / sb; r = sa % sb;
                    e.lo = q[31:0]; e.hi = r[31:0]; e.lat = DIV_LAT;
                end
            end
            4'd8:  e.lo = a << amt;
            4'd9:  e.lo = a >> amt;
            4'd10: begin r = sa >>> amt; e.lo = r[31:0]; end
            4'd11: begin for (int k = 0; k < amt; k++) v = {v[W-2:0], v[W-1]}; e.lo = v; end
            4'd12: begin for (int k = 0; k < amt; k++) v = {v[0], v[W-1:1]}; e.lo = v; end
            default: e.lo = '0;
        endcase
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return MINV;
            4: return MAXV;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (done) begin
            check("busy_at_done", 64'(busy), 64'(0));
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no result (t=%0t)", $time);
            end else begin
                mon_e = sbq.pop_front();
                check("result_lo", 64'(result_lo), 64'(mon_e.lo));
                check("result_hi", 64'(result_hi), 64'(mon_e.hi));
                check("overflow", 64'(overflow), 64'(mon_e.ovf));
                check("div_zero", 64'(div_zero), 64'(mon_e.dz));
                check("latency", 64'(cyc - mon_e.t0 + 1), 64'(mon_e.lat));
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clock);
        while ((busy || done || sbq.size() != 0) && k < 200) begin
            @(negedge clock);
            k++;
        end
        if (k >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got no done within 200 cycles, expected %0d pending", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic issue(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        wait_idle();
        e    = model(op, a, b);
        e.t0 = cyc + 1;
        sbq.push_back(e);
        opcode  = op;
        input_a = a;
        input_b = b;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        opcode  = 4'($urandom);
        input_a = $urandom;
        input_b = $urandom;
    endtask

    initial begin
        clear   = 1'b1;
        start   = 1'b0;
        opcode  = '0;
        input_a = '0;
        input_b = '0;
        repeat (2) @(negedge clock);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_lo", 64'(result_lo), 64'(0));
        check("rst_hi", 64'(result_hi), 64'(0));
        check("rst_ovf", 64'(overflow), 64'(0));
        check("rst_dz", 64'(div_zero), 64'(0));
        clear = 1'b0;

        issue(4'd3, 32'd20, 32'd5);
        issue(4'd3, MAXV, 32'd1);
        issue(4'd6, -32'sd20, 32'd5);
        issue(4'd7, 32'd20, -32'sd3);
        issue(4'd7, 32'd20, 32'd0);
        issue(4'd12, 32'hB2, 32'd2);
        issue(4'd10, MINV, 32'd4);
        issue(4'd8, 32'hB2, 32'd34);
        issue(4'd7, MINV, '1);
        issue(4'd5, MINV, 32'd0);
        issue(4'd6, MINV, MINV);
        issue(4'd7, -32'sd7, 32'd2);
        issue(4'd11, 32'h8000_0001, 32'd33);
        issue(4'd14, 32'hFFFF, 32'hFFFF);

        // A start arriving during the DONE cycle must be dropped
        issue(4'd4, 32'd5, 32'd9);
        opcode  = 4'd3;
        input_a = 32'd100;
        input_b = 32'd200;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;

        // A start pulse with new operands while MUL is running is ignored
        issue(4'd6, -32'sd20, 32'd5);
        repeat (4) @(negedge clock);
        opcode  = 4'd6;
        input_a = 32'd3;
        input_b = 32'd4;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;

        // clear in the middle of MUL aborts everything at once
        issue(4'd6, 32'd12345, -32'sd678);
        repeat (9) @(negedge clock);
        clear = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_lo", 64'(result_lo), 64'(0));
        check("abort_hi", 64'(result_hi), 64'(0));
        check("abort_ovf", 64'(overflow), 64'(0));
        sbq.delete();
        @(negedge clock);
        clear = 1'b0;
        issue(4'd3, 32'd20, 32'd5);

        for (int i = 0; i < 60; i++) begin
            issue(4'($urandom_range(0, 15)), pick(), pick());
        end

        wait_idle();
        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
